mfsk_frame_modulator: RTL and testbench
=======================================

Name: mfsk_frame_modulator

Overview:
- Parametrised continuous-phase M-FSK frame modulator that succeeds the fixed FT8 modulator.
- Builds the frame sync / data / sync / data / sync. Each sync block is a parameterised Costas pattern. Data tones arrive on a valid/ready stream.
- Holds each tone for SAMPLES_PER_SYM sample strobes and drives a phase word to the downstream sine LUT/DAC stage.
- Sits between the LDPC/Gray-mapping symbol source and the sine lookup.

Parameters:
TONE_BITS, 3, bits per tone index (M = 2^TONE_BITS)
PHASE_W, 24, phase accumulator / frequency-control-word width
SYNC_LEN, 7, symbols per Costas sync block
DATA_LEN, 29, data symbols per data block (frame = 3*SYNC_LEN + 2*DATA_LEN = 79 at defaults)
SAMPLES_PER_SYM, 1920, sample strobes per symbol (12 kHz * 0.16 s)
COSTAS, {3'd3,3'd1,3'd4,3'd0,3'd6,3'd5,3'd2}, SYNC_LEN*TONE_BITS-bit sync pattern, element 0 in MSBs

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
sample_en  in  1  one-cycle sample-rate strobe
start  in  1  begin frame (sampled in IDLE only)
abort  in  1  terminate frame
base_fcw  in  PHASE_W  FCW of tone 0, latched on start
tone_fcw  in  PHASE_W  FCW per tone step, latched on start
sym_valid  in  1  data tone available
sym_data  in  TONE_BITS  data tone index
sym_ready  out  1  block accepts data tone
busy  out  1  frame in progress
done  out  1  one-cycle pulse, frame complete
out_valid  out  1  one-cycle pulse per sample
tone_out  out  TONE_BITS  tone of current sample
phase_out  out  PHASE_W  accumulated phase after current sample
underrun  out  1  sticky: data tone missing at symbol boundary

Behaviour:
- Reset (async, low): state IDLE; all outputs 0; phase accumulator, counters, prefetch register and latched FCWs cleared.
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE after the last sample of symbol 3*SYNC_LEN+2*DATA_LEN-1, or on abort.
  - start while RUN is ignored.
  - abort has priority over all other RUN events. It returns to IDLE next cycle, without a done pulse, and flushes the prefetch register.
- On start: latch both FCWs; clear accumulator, sym_idx, samp_cnt and fetched count; clear underrun; busy=1 from the next cycle.
- Symbol classes by sym_idx:
  - sync for [0,SYNC_LEN), [SYNC_LEN+DATA_LEN, 2*SYNC_LEN+DATA_LEN) and [2*SYNC_LEN+2*DATA_LEN, end).
  - Sync tone = COSTAS element (sym_idx - block start).
  - All other symbols are data.
- Data intake:
  - One-entry prefetch register.
  - sym_ready = busy & !pref_full & fetched < 2*DATA_LEN.
  - Load on sym_valid & sym_ready; the fetched count increments on load.
- Tone selection at the first sample of each data symbol (samp_cnt==0 and sample_en):
  - If pref_full: consume the prefetch register (pref_full clears the same cycle).
  - Otherwise: tone=0, underrun<=1. The slot is still counted, so frame timing never stalls.
  - The tone is held for the whole symbol.
- Per sample_en in RUN: acc <= acc + base_fcw + tone*tone_fcw, all mod 2^PHASE_W (the multiply is truncated to PHASE_W).
- Outputs are registered. The cycle after sample_en: out_valid=1, phase_out=new acc, tone_out=tone used.
- Continuous phase: acc is never reset at symbol boundaries.
- samp_cnt wraps at SAMPLES_PER_SYM-1; sym_idx increments on wrap.
- At the last sample of the frame: done=1 coincident with the final out_valid, busy=0 the same cycle. start is accepted again from the next cycle.
- sample_en is ignored in IDLE.
- Idle outputs: tone_out and phase_out hold their last values; out_valid=0.

Test Plan:
1. Bench params SAMPLES_PER_SYM=4, base_fcw=0x000100, tone_fcw=0x000010, sample_en every cycle, data tones 0..7 cyclic -> first out_valid phase_out=0x000130 and tone_out=3; exactly 316 out_valid pulses; tone_out sequence Costas(7)/data(29)/Costas/data/Costas; done on pulse 316; underrun=0.
2. Sync-to-data boundary -> sym_idx 7 uses the first streamed tone (0). Phase continuity: phase_out(n+1)-phase_out(n)=0x100+tone*0x10 at every sample including boundaries.
3. sym_valid held low from data symbol 10 -> underrun rises at that symbol's first sample, tone_out=0 for 4 samples; total pulse count is still 316.
4. base_fcw=0xFFFFF0, tone 0 frame -> phase_out 0xFFFFF0, 0xFFFFE0: wraps mod 2^24 with no overflow flag.
5. abort at sample 50 -> busy=0 next cycle, no done, sym_ready=0. A new start yields first phase_out=0x000130.
6. reset pulled low mid-frame (sample 100), also start asserted while busy -> all outputs 0 immediately on reset; the start during busy causes no restart (pulse count unchanged).

Source files
------------

// File: rtl/mfsk_frame_modulator.sv
// Continuous-phase M-FSK frame modulator: Costas sync / data / sync / data / sync,
// each tone held for SAMPLES_PER_SYM strobes, emitting the running phase word.
module mfsk_frame_modulator #(
  parameter int TONE_BITS       = 3,
  parameter int PHASE_W         = 24,
  parameter int SYNC_LEN        = 7,
  parameter int DATA_LEN        = 29,
  parameter int SAMPLES_PER_SYM = 1920,
  parameter logic [SYNC_LEN*TONE_BITS-1:0] COSTAS = {3'd3, 3'd1, 3'd4, 3'd0, 3'd6, 3'd5, 3'd2}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 start,
  input  logic                 abort,
  input  logic [PHASE_W-1:0]   base_fcw,
  input  logic [PHASE_W-1:0]   tone_fcw,
  input  logic                 sym_valid,
  input  logic [TONE_BITS-1:0] sym_data,
  output logic                 sym_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 out_valid,
  output logic [TONE_BITS-1:0] tone_out,
  output logic [PHASE_W-1:0]   phase_out,
  output logic                 underrun
);
  localparam int FRAME_LEN = 3*SYNC_LEN + 2*DATA_LEN;
  localparam int SYM_W     = $clog2(FRAME_LEN);
  localparam int SC_W      = (SAMPLES_PER_SYM > 1) ? $clog2(SAMPLES_PER_SYM) : 1;
  localparam int FC_W      = $clog2(2*DATA_LEN + 1);
  localparam int OFF_W     = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int SYNC2     = SYNC_LEN + DATA_LEN;
  localparam int SYNC3     = 2*SYNC_LEN + 2*DATA_LEN;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   base_q, base_d, step_q, step_d, acc_q, acc_d;
  logic [SYM_W-1:0]     sym_idx_q, sym_idx_d;
  logic [SC_W-1:0]      samp_cnt_q, samp_cnt_d;
  logic [FC_W-1:0]      fetched_q, fetched_d;
  logic                 pref_full_q, pref_full_d;
  logic [TONE_BITS-1:0] pref_q, pref_d, cur_tone_q, cur_tone_d;
  logic                 underrun_q, underrun_d, done_q, done_d, out_valid_q, out_valid_d;
  logic [TONE_BITS-1:0] tone_out_q, tone_out_d;
  logic [PHASE_W-1:0]   phase_out_q, phase_out_d;

  logic [TONE_BITS-1:0] costas_lut [SYNC_LEN];
  logic                 is_sync, first_samp, load;
  logic [OFF_W-1:0]     sync_off;
  logic [TONE_BITS-1:0] sample_tone;

  for (genvar gi = 0; gi < SYNC_LEN; gi++) begin : g_costas
    assign costas_lut[gi] = COSTAS[(SYNC_LEN-1-gi)*TONE_BITS +: TONE_BITS];
  end

  always_comb begin
    is_sync  = 1'b0;
    sync_off = '0;
    if (sym_idx_q < SYM_W'(SYNC_LEN)) begin
      is_sync  = 1'b1;
      sync_off = OFF_W'(sym_idx_q);
    end else if (sym_idx_q >= SYM_W'(SYNC2) && sym_idx_q < SYM_W'(SYNC2 + SYNC_LEN)) begin
      is_sync  = 1'b1;
      sync_off = OFF_W'(sym_idx_q - SYM_W'(SYNC2));
    end else if (sym_idx_q >= SYM_W'(SYNC3)) begin
      is_sync  = 1'b1;
      sync_off = OFF_W'(sym_idx_q - SYM_W'(SYNC3));
    end
  end

  assign first_samp = (samp_cnt_q == '0);
  assign sym_ready  = (state_q == RUN) && !pref_full_q && (fetched_q < FC_W'(2*DATA_LEN));
  assign load       = sym_valid && sym_ready;

  // Data tone is chosen on the first sample and then held; a missing tone plays as 0.
  always_comb begin
    sample_tone = cur_tone_q;
    if (is_sync)         sample_tone = costas_lut[sync_off];
    else if (first_samp) sample_tone = pref_full_q ? pref_q : '0;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    step_d      = step_q;
    acc_d       = acc_q;
    sym_idx_d   = sym_idx_q;
    samp_cnt_d  = samp_cnt_q;
    fetched_d   = fetched_q;
    pref_full_d = pref_full_q;
    pref_d      = pref_q;
    cur_tone_d  = cur_tone_q;
    underrun_d  = underrun_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    tone_out_d  = tone_out_q;
    phase_out_d = phase_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          base_d      = base_fcw;
          step_d      = tone_fcw;
          acc_d       = '0;
          sym_idx_d   = '0;
          samp_cnt_d  = '0;
          fetched_d   = '0;
          pref_full_d = 1'b0;
          underrun_d  = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          pref_full_d = 1'b0;
        end else begin
          if (load) begin
            pref_d      = sym_data;
            pref_full_d = 1'b1;
            fetched_d   = fetched_q + FC_W'(1);
          end
          if (sample_en) begin
            if (!is_sync && first_samp) begin
              if (pref_full_q) pref_full_d = 1'b0;
              else             underrun_d  = 1'b1;
            end
            cur_tone_d  = sample_tone;
            acc_d       = acc_q + base_q + PHASE_W'(sample_tone) * step_q;
            out_valid_d = 1'b1;
            tone_out_d  = sample_tone;
            phase_out_d = acc_d;
            if (samp_cnt_q == SC_W'(SAMPLES_PER_SYM - 1)) begin
              samp_cnt_d = '0;
              if (sym_idx_q == SYM_W'(FRAME_LEN - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                sym_idx_d = sym_idx_q + SYM_W'(1);
              end
            end else begin
              samp_cnt_d = samp_cnt_q + SC_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      sym_idx_q   <= '0;
      samp_cnt_q  <= '0;
      fetched_q   <= '0;
      pref_full_q <= 1'b0;
      pref_q      <= '0;
      cur_tone_q  <= '0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      tone_out_q  <= '0;
      phase_out_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      sym_idx_q   <= sym_idx_d;
      samp_cnt_q  <= samp_cnt_d;
      fetched_q   <= fetched_d;
      pref_full_q <= pref_full_d;
      pref_q      <= pref_d;
      cur_tone_q  <= cur_tone_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      tone_out_q  <= tone_out_d;
      phase_out_q <= phase_out_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign tone_out  = tone_out_q;
  assign phase_out = phase_out_q;
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_mfsk_frame_modulator.sv
// Randomised frame bench: each frame's tone/phase sequence is predicted from the
// frame layout and phase arithmetic, then compared pulse by pulse.
module tb_mfsk_frame_modulator;
  localparam int SPS    = 4;
  localparam int NSYM   = 79;
  localparam int NDATA  = 58;
  localparam int NPULSE = NSYM * SPS;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [23:0] base_fcw = '0, tone_fcw = '0;
  logic        sym_valid = 1'b0;
  logic [2:0]  sym_data = '0;
  logic        sym_ready, busy, done, out_valid, underrun;
  logic [2:0]  tone_out;
  logic [23:0] phase_out;

  int n_checks = 0;
  int n_fail   = 0;

  int          costas [7] = '{3, 1, 4, 0, 6, 5, 2};
  logic [2:0]  src [NDATA];
  logic [2:0]  exp_tone [NPULSE];
  logic [23:0] exp_phase [NPULSE];
  logic        exp_und [NPULSE];

  mfsk_frame_modulator #(.SAMPLES_PER_SYM(SPS)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .start(start), .abort(abort),
    .base_fcw(base_fcw), .tone_fcw(tone_fcw), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .busy(busy), .done(done), .out_valid(out_valid),
    .tone_out(tone_out), .phase_out(phase_out), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Expected stream: the frame is laid out as a list of symbols, data slots draw
  // the supplied tones in order, slots beyond the supply play tone 0 and flag underrun.
  task automatic build_model(input logic [23:0] b, input logic [23:0] st, input int nsup);
    int layout [$];
    int k = 0;
    int n = 0;
    longint acc = 0;
    bit und = 0;
    for (int r = 0; r < 5; r++) begin
      if (r % 2 == 0) for (int i = 0; i < 7; i++) layout.push_back(costas[i]);
      else            for (int i = 0; i < 29; i++) layout.push_back(-1);
    end
    foreach (layout[s]) begin
      int tone = layout[s];
      if (tone < 0) begin
        if (k < nsup) tone = int'(src[k]);
        else begin tone = 0; und = 1; end
        k++;
      end
      for (int j = 0; j < SPS; j++) begin
        acc = (acc + longint'(b) + longint'(tone) * longint'(st)) % (64'd1 << 24);
        exp_tone[n]  = 3'(tone);
        exp_phase[n] = 24'(acc);
        exp_und[n]   = und;
        n++;
      end
    end
  endtask

  task automatic run_frame(input string name, input logic [23:0] b, input logic [23:0] st,
                           input int nsup, input bit rnd_sen, input bit rnd_tone,
                           input int abort_at, input int reset_at, input int busy_start_at);
    int p = 0, sup = 0, cyc = 0;
    bit fin = 0, sb_done = 0;
    for (int i = 0; i < NDATA; i++) src[i] = rnd_tone ? 3'($urandom_range(0, 7)) : 3'(i % 8);
    build_model(b, st, nsup);

    @(negedge clk);
    base_fcw = b; tone_fcw = st; start = 1'b1; sample_en = 1'b0; sym_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({name, ":busy_after_start"}, 32'(busy), 32'd1);
    check({name, ":underrun_cleared"}, 32'(underrun), 32'd0);

    while (!fin && cyc < 4000) begin
      if (reset_at >= 0 && p == reset_at) begin
        sample_en = 1'b0; sym_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check({name, ":rst_busy"}, 32'(busy), 32'd0);
        check({name, ":rst_outs"}, {out_valid, done, underrun, sym_ready, tone_out, phase_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        fin = 1;
      end else begin
        abort = (abort_at >= 0 && p == abort_at);
        start = (busy_start_at >= 0 && p == busy_start_at && !sb_done);
        if (start) sb_done = 1;
        sample_en = rnd_sen ? ($urandom_range(0, 2) != 0) : 1'b1;
        sym_valid = (sup < nsup);
        sym_data  = src[(sup < NDATA) ? sup : 0];
        if (sym_valid && sym_ready) sup++;
        @(negedge clk);
        cyc++;
        if (abort) begin
          abort = 1'b0;
          check({name, ":abort_busy"}, 32'(busy), 32'd0);
          check({name, ":abort_done"}, 32'(done), 32'd0);
          check({name, ":abort_ready"}, 32'(sym_ready), 32'd0);
          check({name, ":abort_valid"}, 32'(out_valid), 32'd0);
          fin = 1;
        end else if (out_valid) begin
          check({name, ":tone"}, 32'(tone_out), 32'(exp_tone[p]));
          check({name, ":phase"}, 32'(phase_out), 32'(exp_phase[p]));
          check({name, ":underrun"}, 32'(underrun), 32'(exp_und[p]));
          check({name, ":done"}, 32'(done), 32'(p == NPULSE - 1));
          check({name, ":busy"}, 32'(busy), 32'(p != NPULSE - 1));
          p++;
          if (p == NPULSE) fin = 1;
        end else begin
          check({name, ":done_idle"}, 32'(done), 32'd0);
        end
      end
    end
    start = 1'b0; abort = 1'b0; sym_valid = 1'b0;
    check({name, ":frame_ended"}, 32'(fin), 32'd1);
    if (abort_at < 0 && reset_at < 0) begin
      check({name, ":pulse_count"}, 32'(p), 32'(NPULSE));
      sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
      check({name, ":idle_valid"}, 32'(out_valid), 32'd0);
      check({name, ":idle_busy"}, 32'(busy), 32'd0);
      check({name, ":idle_hold_phase"}, 32'(phase_out), 32'(exp_phase[NPULSE-1]));
      check({name, ":idle_hold_tone"}, 32'(tone_out), 32'(exp_tone[NPULSE-1]));
    end
    $display("frame %s base=%06h step=%06h supplied=%0d pulses=%0d cycles=%0d", name, b, st, nsup, p, cyc);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outs", {out_valid, done, underrun, sym_ready, tone_out, phase_out}, 32'd0);
    reset = 1'b1;

    run_frame("nominal",  24'h000100, 24'h000010, NDATA, 0, 0, -1, -1, 20);
    run_frame("random",   24'($urandom), 24'($urandom), NDATA, 1, 1, -1, -1, -1);
    run_frame("underrun", 24'h000100, 24'h000010, 10, 1, 1, -1, -1, -1);
    run_frame("wrap",     24'hFFFFF0, 24'h000000, NDATA, 0, 1, -1, -1, -1);
    run_frame("abort",    24'h000100, 24'h000010, NDATA, 1, 1, 50, -1, -1);
    run_frame("restart",  24'h000100, 24'h000010, NDATA, 0, 0, -1, -1, -1);
    run_frame("reset",    24'($urandom), 24'($urandom), NDATA, 1, 1, -1, 100, -1);
    run_frame("final",    24'($urandom), 24'($urandom), NDATA, 1, 1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
